// File: rtl/moore_seq_pkg.sv
// Shared types and the serial Moore machine's transition/output rules
// for the pattern sequencer.
package moore_seq_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } moore_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } ctrl_state_t;

  localparam moore_state_t MOORE_RESET_STATE = S0;

  function automatic logic moore_out(input moore_state_t s);
    return (s == S1) || (s == S2);
  endfunction

  function automatic moore_state_t moore_next(input moore_state_t s, input logic din);
    moore_state_t n;
    case (s)
      S0:      n = din ? S2 : S1;
      S1:      n = din ? S3 : S2;
      S2:      n = din ? S3 : S1;
      default: n = din ? S0 : S2;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/moore_core.sv
// Serial 4-state Moore machine: clears to S0, advances one bit per
// enabled clock, holds otherwise.
module moore_core
  import moore_seq_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output moore_state_t state,
  output logic         dout
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state <= MOORE_RESET_STATE;
    end else if (en) begin
      state <= moore_next(state, din);
    end
  end

  assign dout = moore_out(state);

endmodule

// File: rtl/moore_seq_ctrl.sv
// Feeds a latched parallel pattern LSB-first into moore_core and gathers
// the Moore output after each step into a parallel result word.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last run's values
// RUN   | one pattern bit applied per clock (busy=1)
// DONE  | single-cycle done pulse, start not accepted
module moore_seq_ctrl
  import moore_seq_pkg::*;
#(
  parameter int LEN = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic [LEN-1:0] pattern,
  output logic           busy,
  output logic           done,
  output logic [LEN-1:0] result,
  output logic [1:0]     final_state
);

  localparam int CW = $clog2(LEN + 1);

  ctrl_state_t   st, st_nxt;
  logic [LEN-1:0] pattern_q;
  logic [LEN-1:0] bit_sel;
  logic [CW-1:0]  steps_left;
  moore_state_t   core_state;
  moore_state_t   step_state;
  logic           step_out;
  logic           last_step;
  logic           core_clr;
  logic           core_en;
  logic           unused_core_dout;

  // Result bits come from the state the core is about to enter, so the
  // last bit is in place on the same edge as the final step.
  assign step_state = moore_next(core_state, pattern_q[0]);
  assign step_out   = moore_out(step_state);
  assign last_step  = (steps_left == '0);

  moore_core u_core (
    .clk   (clk),
    .rst   (rst),
    .clr   (core_clr),
    .en    (core_en),
    .din   (pattern_q[0]),
    .state (core_state),
    .dout  (unused_core_dout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
    end else begin
      st <= st_nxt;
    end
  end

  always_comb begin
    st_nxt   = st;
    core_clr = 1'b0;
    core_en  = 1'b0;
    case (st)
      IDLE: begin
        if (start) begin
          st_nxt   = RUN;
          core_clr = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          st_nxt   = IDLE;
          core_clr = 1'b1;
        end else begin
          core_en = 1'b1;
          if (last_step) st_nxt = DONE;
        end
      end
      DONE:    st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q   <= '0;
      bit_sel     <= '0;
      steps_left  <= '0;
      result      <= '0;
      final_state <= 2'b00;
    end else begin
      if (st == IDLE && start) begin
        pattern_q  <= pattern;
        result     <= '0;
        bit_sel    <= LEN'(1);
        steps_left <= CW'(LEN - 1);
      end else if (st == RUN && !abort) begin
        pattern_q  <= pattern_q >> 1;
        bit_sel    <= bit_sel << 1;
        steps_left <= steps_left - CW'(1);
        if (step_out) result <= result | bit_sel;
        if (last_step) final_state <= step_state;
      end
    end
  end

  assign busy = (st == RUN);
  assign done = (st == DONE);

endmodule

// File: tb/tb_moore_seq_ctrl.sv
// Randomized and directed checks of moore_seq_ctrl (LEN=8 and LEN=1)
// against a table-walk reference model of the Moore machine.
module tb_moore_seq_ctrl;

  logic       clk;
  logic       rst, start, abort;
  logic [7:0] pattern;
  logic       busy, done;
  logic [7:0] result;
  logic [1:0] fs;

  logic       rst1, start1, abort1;
  logic [0:0] pattern1;
  logic       busy1, done1;
  logic [0:0] result1;
  logic [1:0] fs1;

  int n_checks = 0;
  int n_pass   = 0;

  int nxt_tab [4][2];
  int out_tab [4];

  logic [7:0] exp_res8;
  logic [1:0] exp_fs8;

  moore_seq_ctrl #(.LEN(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pattern(pattern),
    .busy(busy), .done(done), .result(result), .final_state(fs)
  );

  moore_seq_ctrl #(.LEN(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .abort(abort1), .pattern(pattern1),
    .busy(busy1), .done(done1), .result(result1), .final_state(fs1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [31:0] pat, input int nbits,
                                output logic [31:0] res, output logic [1:0] f);
    int s;
    s   = 0;
    res = '0;
    for (int k = 0; k < nbits; k++) begin
      s      = nxt_tab[s][pat[k]];
      res[k] = (out_tab[s] != 0);
    end
    f = 2'(s);
  endfunction

  task automatic accept8(input logic [7:0] pat);
    start   = 1'b1;
    pattern = pat;
    check("idle_busy", {31'b0, busy}, 0);
    tick;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic body8(input logic [7:0] pat, input int abort_at, input int rst_at,
                       input bit noise, input bit mid_en, input logic [7:0] mid_pat);
    logic [31:0] r;
    logic [1:0]  f;
    for (int i = 1; i <= 8; i++) begin
      check("busy_run", {31'b0, busy}, 1);
      check("done_run", {31'b0, done}, 0);
      if (mid_en && i == 4) pattern = mid_pat;
      if (noise) begin
        pattern = 8'($urandom);
        start   = 1'($urandom_range(0, 1));
      end
      if (i == abort_at) abort = 1'b1;
      if (i == rst_at) rst = 1'b1;
      tick;
      abort = 1'b0;
      rst   = 1'b0;
      if (i == rst_at) begin
        if (noise) start = 1'b0;
        exp_res8 = '0;
        exp_fs8  = '0;
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_result", {24'b0, result}, {24'b0, exp_res8});
        check("rst_final", {30'b0, fs}, {30'b0, exp_fs8});
        return;
      end
      if (i == abort_at) begin
        if (noise) start = 1'b0;
        model({24'b0, pat}, i - 1, r, f);
        exp_res8 = r[7:0];
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_done", {31'b0, done}, 0);
        check("abort_result", {24'b0, result}, {24'b0, exp_res8});
        check("abort_final", {30'b0, fs}, {30'b0, exp_fs8});
        return;
      end
    end
    model({24'b0, pat}, 8, r, f);
    exp_res8 = r[7:0];
    exp_fs8  = f;
    check("done_pulse", {31'b0, done}, 1);
    check("done_busy", {31'b0, busy}, 0);
    check("result", {24'b0, result}, {24'b0, exp_res8});
    check("final_state", {30'b0, fs}, {30'b0, exp_fs8});
    if (noise) abort = 1'($urandom_range(0, 1));
    tick;
    abort = 1'b0;
    if (noise) start = 1'b0;
    check("done_drop", {31'b0, done}, 0);
    check("idle_after", {31'b0, busy}, 0);
    check("result_hold", {24'b0, result}, {24'b0, exp_res8});
  endtask

  task automatic run1(input logic pat);
    logic [31:0] r;
    logic [1:0]  f;
    model({31'b0, pat}, 1, r, f);
    start1   = 1'b1;
    pattern1 = pat;
    tick;
    start1   = 1'b0;
    pattern1 = ~pat;
    check("l1_busy", {31'b0, busy1}, 1);
    tick;
    check("l1_done", {31'b0, done1}, 1);
    check("l1_result", {31'b0, result1}, {31'b0, r[0]});
    check("l1_final", {30'b0, fs1}, {30'b0, f});
    tick;
    check("l1_done_drop", {31'b0, done1}, 0);
  endtask

  initial begin
    logic [7:0] p;
    int ab;
    nxt_tab = '{'{1, 2}, '{2, 3}, '{1, 3}, '{2, 0}};
    out_tab = '{0, 1, 1, 0};
    rst = 1'b1; start = 1'b0; abort = 1'b0; pattern = '0;
    rst1 = 1'b1; start1 = 1'b0; abort1 = 1'b0; pattern1 = '0;
    tick;
    tick;
    rst = 1'b0;
    rst1 = 1'b0;
    exp_res8 = '0;
    exp_fs8  = '0;
    check("reset_busy", {31'b0, busy}, 0);
    check("reset_done", {31'b0, done}, 0);
    check("reset_result", {24'b0, result}, 0);
    check("reset_final", {30'b0, fs}, 0);
    check("reset_busy1", {31'b0, busy1}, 0);
    check("reset_result1", {31'b0, result1}, 0);

    accept8(8'h5C); body8(8'h5C, 0, 0, 0, 0, 8'h00);
    check("t1_const_result", {24'b0, result}, 32'hB3);
    check("t1_const_final", {30'b0, fs}, 32'h2);

    accept8(8'h00); body8(8'h00, 0, 0, 0, 0, 8'h00);
    check("t2a_const_result", {24'b0, result}, 32'hFF);
    check("t2a_const_final", {30'b0, fs}, 32'h2);
    accept8(8'hFF); body8(8'hFF, 0, 0, 0, 0, 8'h00);
    check("t2b_const_result", {24'b0, result}, 32'h49);
    check("t2b_const_final", {30'b0, fs}, 32'h3);

    // start held through a run; pattern switched to FF mid-run
    start = 1'b1; pattern = 8'h5C;
    tick;
    body8(8'h5C, 0, 0, 0, 1, 8'hFF);
    check("t3_const_result", {24'b0, result}, 32'hB3);
    tick;
    start = 1'b0;
    body8(8'hFF, 0, 0, 0, 0, 8'h00);
    check("t3_second_result", {24'b0, result}, 32'h49);

    accept8(8'h5C); body8(8'h5C, 4, 0, 0, 0, 8'h00);
    check("t4_const_result", {24'b0, result}, 32'h03);
    check("t4_const_final", {30'b0, fs}, 32'h3);

    accept8(8'h5C); body8(8'h5C, 0, 5, 0, 0, 8'h00);
    check("t5_const_result", {24'b0, result}, 32'h0);
    accept8(8'h5C); body8(8'h5C, 0, 0, 0, 0, 8'h00);
    check("t5_const_after", {24'b0, result}, 32'hB3);

    for (int n = 0; n < 40; n++) begin
      p  = 8'($urandom);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
        abort = 1'($urandom_range(0, 1));
        tick;
        abort = 1'b0;
        check("gap_idle", {31'b0, busy}, 0);
      end
      accept8(p);
      body8(p, ab, 0, 1, 0, 8'h00);
    end

    run1(1'b1);
    check("t6_const_result", {31'b0, result1}, 32'h1);
    check("t6_const_final", {30'b0, fs1}, 32'h2);
    run1(1'b0);
    check("t6b_const_result", {31'b0, result1}, 32'h1);
    check("t6b_const_final", {30'b0, fs1}, 32'h1);
    for (int n = 0; n < 6; n++) run1(1'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
